hazard_fwd_ctrl: RTL and testbench

Pipeline hazard and forwarding controller for the 5-stage 64-bit core. It tracks the destination-register tags of the instructions in EX, MEM and WB. From those it produces the stall, flush and forwarding selects that the ID/EX operand register, the IF/ID register and the PC consume. It is the producer side of the ID/EX operand interface: it generates `IDEXstall`, `IDEXflush`, `rs1_forwarding`/`rs2_forwarding` and the WB-retire timing that the operand register's stall-time write-back capture depends on.

---
 rtl/hazard_fwd_ctrl.sv | 152 +++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller: tracks EX/MEM/WB destination tags and
// derives stall, flush and operand-forwarding selects for the 5-stage core.
module hazard_fwd_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] id_rd,
    input  logic       id_we,
    input  logic       id_is_load,
    input  logic       mem_req,
    input  logic       mem_ack,
    input  logic       ex_redirect,
    output logic       pc_stall,
    output logic       IFIDstall,
    output logic       IFIDflush,
    output logic       IDEXstall,
    output logic       IDEXflush,
    output logic       EXMEMstall,
    output logic [1:0] rs1_forwarding,
    output logic [1:0] rs2_forwarding
);

    logic       r_ex_valid;
    logic       r_ex_we;
    logic       r_ex_is_load;
    logic       r_ex_use_rs1;
    logic       r_ex_use_rs2;
    logic [4:0] r_ex_rd;
    logic [4:0] r_ex_rs1;
    logic [4:0] r_ex_rs2;

    logic       r_mem_valid;
    logic       r_mem_we;
    logic       r_mem_is_load;
    logic [4:0] r_mem_rd;

    logic       r_wb_valid;
    logic       r_wb_we;
    logic [4:0] r_wb_rd;

    logic w_mem_busy;
    logic w_ex_eff;
    logic w_mem_eff;
    logic w_wb_eff;
    logic w_load_use;
    logic w_ex_bubble;
    logic w_rs1_mem;
    logic w_rs1_wb;
    logic w_rs2_mem;
    logic w_rs2_wb;

    // A write to x0 is architecturally void, so such a slot never matches.
    assign w_ex_eff  = r_ex_valid  & r_ex_we  & (r_ex_rd  != 5'd0);
    assign w_mem_eff = r_mem_valid & r_mem_we & (r_mem_rd != 5'd0);
    assign w_wb_eff  = r_wb_valid  & r_wb_we  & (r_wb_rd  != 5'd0);

    assign w_mem_busy = mem_req & ~mem_ack;

    assign w_load_use = id_valid & w_ex_eff & r_ex_is_load &
                        ((id_use_rs1 & (id_rs1 == r_ex_rd)) |
                         (id_use_rs2 & (id_rs2 == r_ex_rd)));

    assign w_ex_bubble = ex_redirect | w_load_use;

    // A load in MEM is skipped so the select falls through to WB or the regfile.
    assign w_rs1_mem = r_ex_valid & r_ex_use_rs1 & w_mem_eff & ~r_mem_is_load &
                       (r_mem_rd == r_ex_rs1);
    assign w_rs1_wb  = r_ex_valid & r_ex_use_rs1 & w_wb_eff & (r_wb_rd == r_ex_rs1);
    assign w_rs2_mem = r_ex_valid & r_ex_use_rs2 & w_mem_eff & ~r_mem_is_load &
                       (r_mem_rd == r_ex_rs2);
    assign w_rs2_wb  = r_ex_valid & r_ex_use_rs2 & w_wb_eff & (r_wb_rd == r_ex_rs2);

    always_comb begin
        rs1_forwarding = 2'b00;
        rs2_forwarding = 2'b00;
        if (!rst) begin
            if (w_rs1_mem)     rs1_forwarding = 2'b01;
            else if (w_rs1_wb) rs1_forwarding = 2'b10;
            if (w_rs2_mem)     rs2_forwarding = 2'b01;
            else if (w_rs2_wb) rs2_forwarding = 2'b10;
        end
    end

    always_comb begin
        pc_stall   = 1'b0;
        IFIDstall  = 1'b0;
        IFIDflush  = 1'b0;
        IDEXstall  = 1'b0;
        IDEXflush  = 1'b0;
        EXMEMstall = 1'b0;
        if (!rst) begin
            if (w_mem_busy) begin
                pc_stall   = 1'b1;
                IFIDstall  = 1'b1;
                IDEXstall  = 1'b1;
                EXMEMstall = 1'b1;
            end else if (ex_redirect) begin
                IFIDflush  = 1'b1;
                IDEXflush  = 1'b1;
            end else if (w_load_use) begin
                pc_stall   = 1'b1;
                IFIDstall  = 1'b1;
                IDEXflush  = 1'b1;
            end
        end
    end

    // During a freeze the WB instruction retires on the first edge, so only
    // its slot is cleared while EX and MEM hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid    <= 1'b0;
            r_ex_we       <= 1'b0;
            r_ex_is_load  <= 1'b0;
            r_ex_use_rs1  <= 1'b0;
            r_ex_use_rs2  <= 1'b0;
            r_ex_rd       <= 5'd0;
            r_ex_rs1      <= 5'd0;
            r_ex_rs2      <= 5'd0;
            r_mem_valid   <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_is_load <= 1'b0;
            r_mem_rd      <= 5'd0;
            r_wb_valid    <= 1'b0;
            r_wb_we       <= 1'b0;
            r_wb_rd       <= 5'd0;
        end else if (w_mem_busy) begin
            r_wb_valid    <= 1'b0;
        end else begin
            r_wb_valid    <= r_mem_valid;
            r_wb_we       <= r_mem_we;
            r_wb_rd       <= r_mem_rd;
            r_mem_valid   <= r_ex_valid;
            r_mem_we      <= r_ex_we;
            r_mem_is_load <= r_ex_is_load;
            r_mem_rd      <= r_ex_rd;
            r_ex_valid    <= id_valid & ~w_ex_bubble;
            r_ex_we       <= id_we;
            r_ex_is_load  <= id_is_load;
            r_ex_use_rs1  <= id_use_rs1;
            r_ex_use_rs2  <= id_use_rs2;
            r_ex_rd       <= id_rd;
            r_ex_rs1      <= id_rs1;
            r_ex_rs2      <= id_rs2;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: each scenario is a table of per-cycle
// inputs and hand-derived expected control/forwarding vectors.
module tb_hazard_fwd_ctrl;

    // Expected vector layout: {pc_stall, IFIDstall, IFIDflush, IDEXstall,
    // IDEXflush, EXMEMstall, rs1_forwarding, rs2_forwarding}
    localparam logic [9:0] E_NONE = 10'b00_0000_0000;
    localparam logic [9:0] E_LU   = 10'b11_0010_0000;
    localparam logic [9:0] E_RD   = 10'b00_1010_0000;
    localparam logic [9:0] E_FZ   = 10'b11_0101_0000;
    localparam logic [9:0] F1_MEM = 10'b00_0000_0100;
    localparam logic [9:0] F1_WB  = 10'b00_0000_1000;
    localparam logic [9:0] F2_WB  = 10'b00_0000_0010;

    typedef struct {
        logic       rst;
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       req;
        logic       ack;
        logic       redir;
        logic [9:0] exp;
    } step_t;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] id_rd;
    logic       id_we;
    logic       id_is_load;
    logic       mem_req;
    logic       mem_ack;
    logic       ex_redirect;
    logic       pc_stall;
    logic       IFIDstall;
    logic       IFIDflush;
    logic       IDEXstall;
    logic       IDEXflush;
    logic       EXMEMstall;
    logic [1:0] rs1_forwarding;
    logic [1:0] rs2_forwarding;

    logic [9:0] w_got;
    logic [9:0] exp_q[$];
    int         n_run;
    int         n_fail;

    hazard_fwd_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .id_rd          (id_rd),
        .id_we          (id_we),
        .id_is_load     (id_is_load),
        .mem_req        (mem_req),
        .mem_ack        (mem_ack),
        .ex_redirect    (ex_redirect),
        .pc_stall       (pc_stall),
        .IFIDstall      (IFIDstall),
        .IFIDflush      (IFIDflush),
        .IDEXstall      (IDEXstall),
        .IDEXflush      (IDEXflush),
        .EXMEMstall     (EXMEMstall),
        .rs1_forwarding (rs1_forwarding),
        .rs2_forwarding (rs2_forwarding)
    );

    assign w_got = {pc_stall, IFIDstall, IFIDflush, IDEXstall, IDEXflush,
                    EXMEMstall, rs1_forwarding, rs2_forwarding};

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic step_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic we, input logic ld, input logic req,
                                 input logic ack, input logic redir, input logic [9:0] exp);
        step_t s;
        s.rst = 1'b0; s.v = v; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2;
        s.rd = rd; s.we = we; s.ld = ld; s.req = req; s.ack = ack; s.redir = redir;
        s.exp = exp;
        return s;
    endfunction

    function automatic step_t nop(input logic req, input logic ack, input logic redir,
                                  input logic [9:0] exp);
        return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, req, ack, redir, exp);
    endfunction

    // Driver: inputs are applied just after a rising edge and hold for the cycle.
    task automatic apply(input step_t s);
        rst         = s.rst;
        id_valid    = s.v;
        id_rs1      = s.rs1;
        id_rs2      = s.rs2;
        id_use_rs1  = s.u1;
        id_use_rs2  = s.u2;
        id_rd       = s.rd;
        id_we       = s.we;
        id_is_load  = s.ld;
        mem_req     = s.req;
        mem_ack     = s.ack;
        ex_redirect = s.redir;
    endtask

    task automatic test_reset();
        step_t st[$];
        logic [9:0] e;
        for (int i = 0; i < 2; i++) begin
            step_t s;
            s = mk(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                   5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), E_NONE);
            s.rst = 1'b1;
            if (i == 1) begin
                s.req = 1'b1;
                s.ack = 1'b0;
            end
            st.push_back(s);
        end
        st.push_back(mk(1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_NONE));
        st.push_back(mk(1'b0, 5'd3, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        st.push_back(nop(1'b0, 1'b0, 1'b0, E_NONE));
        foreach (st[i]) begin
            apply(st[i]);
            exp_q.push_back(st[i].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            n_run++;
            if (w_got !== e) begin
                n_fail++;
                $display("FAIL reset step %0d: got %b expected %b", i, w_got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_fwd();
        step_t st[$];
        logic [9:0] e;
        st.push_back(mk(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        st.push_back(mk(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        st.push_back(nop(1'b0, 1'b0, 1'b0, F1_MEM));
        st.push_back(nop(1'b0, 1'b0, 1'b0, E_NONE));
        foreach (st[i]) begin
            apply(st[i]);
            exp_q.push_back(st[i].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            n_run++;
            if (w_got !== e) begin
                n_fail++;
                $display("FAIL mem_fwd step %0d: got %b expected %b", i, w_got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wb_fwd();
        step_t st[$];
        logic [9:0] e;
        st.push_back(mk(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        st.push_back(mk(1'b1, 5'd10, 5'd11, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        st.push_back(mk(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        st.push_back(nop(1'b0, 1'b0, 1'b0, F1_WB));
        st.push_back(nop(1'b0, 1'b0, 1'b0, E_NONE));
        foreach (st[i]) begin
            apply(st[i]);
            exp_q.push_back(st[i].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            n_run++;
            if (w_got !== e) begin
                n_fail++;
                $display("FAIL wb_fwd step %0d: got %b expected %b", i, w_got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_x0();
        step_t st[$];
        logic [9:0] e;
        st.push_back(mk(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        st.push_back(mk(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        st.push_back(mk(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        st.push_back(nop(1'b0, 1'b0, 1'b0, E_NONE));
        st.push_back(nop(1'b0, 1'b0, 1'b0, E_NONE));
        foreach (st[i]) begin
            apply(st[i]);
            exp_q.push_back(st[i].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            n_run++;
            if (w_got !== e) begin
                n_fail++;
                $display("FAIL x0_fwd step %0d: got %b expected %b", i, w_got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        step_t st[$];
        logic [9:0] e;
        st.push_back(mk(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_NONE));
        st.push_back(mk(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_LU));
        st.push_back(mk(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        st.push_back(nop(1'b0, 1'b0, 1'b0, F1_WB | F2_WB));
        st.push_back(nop(1'b0, 1'b0, 1'b0, E_NONE));
        foreach (st[i]) begin
            apply(st[i]);
            exp_q.push_back(st[i].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            n_run++;
            if (w_got !== e) begin
                n_fail++;
                $display("FAIL load_use step %0d: got %b expected %b", i, w_got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_freeze();
        step_t st[$];
        logic [9:0] e;
        st.push_back(mk(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        st.push_back(mk(1'b1, 5'd10, 5'd11, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        st.push_back(mk(1'b1, 5'd9, 5'd13, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        st.push_back(nop(1'b1, 1'b0, 1'b0, E_FZ | F1_WB));
        st.push_back(nop(1'b1, 1'b0, 1'b0, E_FZ));
        st.push_back(nop(1'b1, 1'b0, 1'b0, E_FZ));
        st.push_back(mk(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 5'd14, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, E_NONE));
        st.push_back(nop(1'b0, 1'b0, 1'b0, F1_MEM));
        st.push_back(nop(1'b0, 1'b0, 1'b0, E_NONE));
        foreach (st[i]) begin
            apply(st[i]);
            exp_q.push_back(st[i].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            n_run++;
            if (w_got !== e) begin
                n_fail++;
                $display("FAIL freeze step %0d: got %b expected %b", i, w_got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect_freeze();
        step_t st[$];
        logic [9:0] e;
        st.push_back(mk(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_NONE));
        st.push_back(mk(1'b1, 5'd15, 5'd0, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, E_FZ));
        st.push_back(mk(1'b1, 5'd15, 5'd0, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, E_FZ));
        st.push_back(mk(1'b1, 5'd15, 5'd0, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, E_RD));
        st.push_back(nop(1'b0, 1'b0, 1'b0, E_NONE));
        foreach (st[i]) begin
            apply(st[i]);
            exp_q.push_back(st[i].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            n_run++;
            if (w_got !== e) begin
                n_fail++;
                $display("FAIL redirect_freeze step %0d: got %b expected %b", i, w_got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect_load_use();
        step_t st[$];
        logic [9:0] e;
        st.push_back(mk(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd20, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_NONE));
        st.push_back(mk(1'b1, 5'd20, 5'd20, 1'b1, 1'b1, 5'd21, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, E_RD));
        st.push_back(nop(1'b0, 1'b0, 1'b0, E_NONE));
        st.push_back(nop(1'b0, 1'b0, 1'b0, E_NONE));
        foreach (st[i]) begin
            apply(st[i]);
            exp_q.push_back(st[i].exp);
            @(negedge clk);
            e = exp_q.pop_front();
            n_run++;
            if (w_got !== e) begin
                n_fail++;
                $display("FAIL redirect_load_use step %0d: got %b expected %b", i, w_got, e);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        apply(nop(1'b0, 1'b0, 1'b0, E_NONE));
        rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_mem_fwd();
        test_wb_fwd();
        test_x0();
        test_load_use();
        test_freeze();
        test_redirect_freeze();
        test_redirect_load_use();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
